// File: rtl/i2s_tx.sv
// i2s_tx: 24-bit stereo I2S transmitter in 32-bit slots with standard one-bclk data delay.
// bclk is divided from clk. The serial frame runs continuously, whatever the input rate.
// Optional feature: define I2S_TX_UNDERRUN_MUTE_EN to send silence for a channel that was
// not written since the previous frame and to pulse underrun when that happens. In the
// default build the stale sample is sent again and underrun stays 0.
module i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_ch,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_TC = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_nxt;
    logic [23:0] hold_l, hold_r;
    logic [23:0] sh_l, sh_r;
    logic [23:0] load_l, load_r;
    logic        fresh_l, fresh_r;
    logic        div_tc, fall_evt, latch, stale;

    assign div_tc   = (div_cnt == DIV_TC);
    assign fall_evt = div_tc && bclk;
    assign bit_nxt  = bit_cnt + 6'd1;
    assign latch    = fall_evt && (bit_cnt == 6'd63);

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    assign load_l = fresh_l ? hold_l : 24'd0;
    assign load_r = fresh_r ? hold_r : 24'd0;
    assign stale  = latch && !(fresh_l && fresh_r);
`else
    assign load_l = hold_l;
    assign load_r = hold_r;
    assign stale  = 1'b0;
`endif

    // Bit-clock divider: toggle bclk every BCLK_DIV clk cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 8'd0;
            bclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= 8'd0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Frame sequencer and serializer: all serial outputs move on bclk falling edges only.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= 6'd63;
            lrclk       <= 1'b1;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            sh_l        <= 24'd0;
            sh_r        <= 24'd0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall_evt) begin
                bit_cnt     <= bit_nxt;
                lrclk       <= bit_nxt[5];
                frame_start <= latch;
                underrun    <= stale;
                if (latch) begin
                    sh_l  <= load_l;
                    sh_r  <= load_r;
                    sdata <= 1'b0;
                end else if (bit_nxt >= 6'd1 && bit_nxt <= 6'd24) begin
                    sdata <= sh_l[23];
                    sh_l  <= {sh_l[22:0], 1'b0};
                end else if (bit_nxt >= 6'd33 && bit_nxt <= 6'd56) begin
                    sdata <= sh_r[23];
                    sh_r  <= {sh_r[22:0], 1'b0};
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

    // Holding registers: a write in the latch cycle lands after the latch and stays fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_l  <= 24'd0;
            hold_r  <= 24'd0;
            fresh_l <= 1'b0;
            fresh_r <= 1'b0;
        end else begin
            if (latch) begin
                fresh_l <= 1'b0;
                fresh_r <= 1'b0;
            end
            if (in_valid) begin
                if (in_ch) begin
                    hold_r  <= in_data;
                    fresh_r <= 1'b1;
                end else begin
                    hold_l  <= in_data;
                    fresh_l <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx. It uses a BCLK_DIV=2 instance for the frame
// and data checks, and a BCLK_DIV=1 instance watched by a per-cycle monitor.
module tb_i2s_tx;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_data;
    logic        in_valid, in_ch;
    logic        bclk, lrclk, sdata, frame_start, underrun;
    logic        bclk1, lrclk1, sdata1, frame_start1, underrun1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2s_tx #(.BCLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ch(in_ch),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun)
    );

    i2s_tx #(.BCLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ch(in_ch),
        .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .frame_start(frame_start1),
        .underrun(underrun1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until frame_start; returns cycles taken and underrun seen in that cycle.
    task automatic wait_frame(output int cycles, output logic ur);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!frame_start && cycles < 1000);
        ur = underrun;
    endtask

    // Called in the frame_start cycle; samples bit_cnt 1..63 (one sample per 4 clk).
    task automatic capture(output logic [23:0] l, output logic [23:0] r,
                           output int pad_err, output int lr_err,
                           output logic ur_next, output logic fs_next);
        l = 24'd0; r = 24'd0; pad_err = 0; lr_err = 0; ur_next = 1'b0; fs_next = 1'b0;
        for (int c = 1; c <= 252; c++) begin
            step();
            if (c == 1) begin
                ur_next = underrun;
                fs_next = frame_start;
            end
            if (c % 4 == 0) begin
                int n;
                n = c / 4;
                if (lrclk !== (n >= 32)) lr_err++;
                if (n >= 1 && n <= 24) l[24-n] = sdata;
                else if (n >= 33 && n <= 56) r[56-n] = sdata;
                else if (sdata !== 1'b0) pad_err++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] el, input logic [23:0] er);
        logic [23:0] l, r;
        int pe, le;
        logic un, fn;
        capture(l, r, pe, le, un, fn);
        chk({tag, "_left"}, 32'(l), 32'(el));
        chk({tag, "_right"}, 32'(r), 32'(er));
        chk({tag, "_pad"}, 32'(pe), 0);
        chk({tag, "_lrclk"}, 32'(le), 0);
        chk({tag, "_ur_width"}, 32'(un), 0);
        chk({tag, "_fs_width"}, 32'(fn), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bclk"}, 32'(bclk), 0);
        chk({tag, "_lrclk"}, 32'(lrclk), 1);
        chk({tag, "_sdata"}, 32'(sdata), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_ur"}, 32'(underrun), 0);
    endtask

    // After release: bclk 0,1,1,0 and the first frame_start on the 4th clk.
    task automatic check_startup(input string tag);
        logic [3:0] bseq, fseq;
        bseq = 4'd0; fseq = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            bseq = {bseq[2:0], bclk};
            fseq = {fseq[2:0], frame_start};
        end
        chk({tag, "_bclk_seq"}, 32'(bseq), 32'h6);
        chk({tag, "_fs_seq"}, 32'(fseq), 32'h1);
    endtask

    // BCLK_DIV=1 monitor: bclk toggles every clk; lrclk/sdata move only on falls.
    int   toggle_bad = 0, change_bad = 0, falls1 = 0, lr_moves1 = 0;
    int   cnt1 = 0, per1 = 0;
    bit   have_prev = 0, have_fs1 = 0;
    logic pb, plr, psd;

    always @(posedge clk) begin
        logic rs;
        rs = reset;
        #1;
        if (rs) begin
            cnt1 = 0;
            have_fs1 = 0;
        end else begin
            if (have_prev) begin
                if (bclk1 === pb) toggle_bad++;
                if (pb && !bclk1) falls1++;
                if ((lrclk1 !== plr || sdata1 !== psd) && !(pb && !bclk1)) change_bad++;
                if (lrclk1 !== plr) lr_moves1++;
            end
            cnt1++;
            if (frame_start1) begin
                if (have_fs1) per1 = cnt1;
                cnt1 = 0;
                have_fs1 = 1;
            end
        end
        pb = bclk1; plr = lrclk1; psd = sdata1;
        have_prev = 1;
    end

    initial begin
        int   cyc;
        logic ur;

        reset = 1'b1; in_valid = 1'b0; in_ch = 1'b0; in_data = 24'd0;
        step(); step(); step();
        check_reset_outputs("rst");
        reset = 1'b0;
        check_startup("start");

        wait_frame(cyc, ur);
        chk("frame_period", 32'(cyc), 256);
        chk("idle_underrun", 32'(ur), 32'(MUTE));
        check_frame("idle", 24'd0, 24'd0);

        in_valid = 1'b1; in_ch = 1'b0; in_data = 24'h800001;
        step();
        in_ch = 1'b1; in_data = 24'h7FFFFE;
        step();
        in_valid = 1'b0;
        wait_frame(cyc, ur);
        chk("data_gap", 32'(cyc), 2);
        chk("data_underrun", 32'(ur), 0);
        check_frame("data", 24'h800001, 24'h7FFFFE);

        step(); step(); step();
        in_valid = 1'b1; in_ch = 1'b0; in_data = 24'h123456;
        step();
        in_valid = 1'b0;
        chk("coin_fs", 32'(frame_start), 1);
        chk("coin_underrun", 32'(underrun), 0);
        check_frame("coin_old", 24'h800001, 24'h7FFFFE);

        wait_frame(cyc, ur);
        chk("coin_gap", 32'(cyc), 4);
        chk("stale_underrun", 32'(ur), 32'(MUTE));
        check_frame("coin_new", 24'h123456, MUTE ? 24'd0 : 24'h7FFFFE);

        wait_frame(cyc, ur);
        chk("pre_rst_gap", 32'(cyc), 4);
        for (int i = 0; i < 160; i++) step();
        chk("bit40_lrclk", 32'(lrclk), 1);
        reset = 1'b1;
        step();
        check_reset_outputs("midrst");
        reset = 1'b0;
        check_startup("restart");
        check_frame("after_rst", 24'd0, 24'd0);

        chk("div1_toggle", 32'(toggle_bad), 0);
        chk("div1_change", 32'(change_bad), 0);
        chk("div1_period", 32'(per1), 128);
        chk("div1_falls_seen", 32'(falls1 > 100), 1);
        chk("div1_lr_moves_seen", 32'(lr_moves1 > 4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
